// File: rtl/keypad_key_fifo.sv
// Key-code FIFO between the keypad scanner and the CPU read mux.
// Edge-detected push/pop/status events; combinational status and data read views.
module keypad_key_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CODE_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       key_valid,
    input  logic [CODE_W-1:0]          key_code,
    input  logic                       ack,
    input  logic                       statusordata,
    output logic [15:0]                data_out,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [CODE_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rp_q, rp_d;
    logic [PW-1:0]     wp_q, wp_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              kv_q, ack_q, st_q;

    logic push_ev, pop_ev, stat_ev;
    logic do_push, do_pop, drop;
    logic [15:0] head_word;

    assign push_ev = key_valid & ~kv_q;
    assign pop_ev  = ack & ~ack_q;
    assign stat_ev = statusordata & ~st_q;

    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign overflow = overflow_q;

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop_ev & ~empty;
    assign do_push = push_ev & (~full | do_pop);
    assign drop    = push_ev & full & ~do_pop;

    always_comb begin
        rp_d       = rp_q;
        wp_d       = wp_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (do_push) begin
            wp_d = wp_q + 1'b1;
        end
        if (do_pop) begin
            rp_d = rp_q + 1'b1;
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
        if (drop) begin
            overflow_d = 1'b1;
        end else if (stat_ev) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rp_q       <= '0;
            wp_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            // Held high so inputs already asserted at release raise no event.
            kv_q       <= 1'b1;
            ack_q      <= 1'b1;
            st_q       <= 1'b1;
        end else begin
            rp_q       <= rp_d;
            wp_q       <= wp_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            kv_q       <= key_valid;
            ack_q      <= ack;
            st_q       <= statusordata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wp_q] <= key_code;
        end
    end

    always_comb begin
        head_word               = '0;
        head_word[CODE_W-1:0]   = mem[rp_q];
        data_out                = 16'h0000;
        if (statusordata) begin
            data_out = {13'b0, overflow_q, full, ~empty};
        end else if (!empty) begin
            data_out = head_word;
        end
    end

endmodule

// File: tb/tb_keypad_key_fifo.sv
// Directed self-checking bench for keypad_key_fifo (DEPTH=4, CODE_W=4).
module tb_keypad_key_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        ack;
    logic        statusordata;
    logic [15:0] data_out;
    logic [2:0]  count;
    logic        empty, full, overflow;

    int tests = 0;
    int fails = 0;

    keypad_key_fifo #(.DEPTH(4), .CODE_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .ack          (ack),
        .statusordata (statusordata),
        .data_out     (data_out),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [3:0] code);
        key_code  = code;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        step();
    endtask

    task automatic ack_hold();
        repeat (4) step();
        ack = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; key_valid = 1'b0; key_code = '0; ack = 1'b0; statusordata = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", empty); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", full); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", overflow); end
        tests++; if (data_out !== 16'h0000) begin fails++; $display("FAIL reset_data got %h want 0000", data_out); end
        statusordata = 1'b1;
        #1;
        tests++; if (data_out !== 16'h0000) begin fails++; $display("FAIL reset_status got %h want 0000", data_out); end
        statusordata = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [3:0] codes [3];
        codes[0] = 4'h5; codes[1] = 4'hA; codes[2] = 4'h3;
        for (int i = 0; i < 3; i++) push(codes[i]);
        tests++; if (count !== 3'd3) begin fails++; $display("FAIL basic_count got %0d want 3", count); end
        for (int i = 0; i < 3; i++) begin
            ack = 1'b1;
            #1;
            tests++; if (data_out !== {12'h000, codes[i]}) begin
                fails++; $display("FAIL basic_pop%0d got %h want %h", i, data_out, {12'h000, codes[i]});
            end
            ack_hold();
            tests++; if (count !== 3'(2 - i)) begin
                fails++; $display("FAIL basic_count%0d got %0d want %0d", i, count, 2 - i);
            end
        end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL basic_empty got %b want 1", empty); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 6; i++) push(4'(i));
        tests++; if (full !== 1'b1) begin fails++; $display("FAIL ovf_full got %b want 1", full); end
        tests++; if (count !== 3'd4) begin fails++; $display("FAIL ovf_count got %0d want 4", count); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b want 1", overflow); end
        statusordata = 1'b1;
        #1;
        tests++; if (data_out !== 16'h0007) begin fails++; $display("FAIL ovf_stat1 got %h want 0007", data_out); end
        step();
        statusordata = 1'b0;
        step();
        statusordata = 1'b1;
        #1;
        tests++; if (data_out !== 16'h0003) begin fails++; $display("FAIL ovf_stat2 got %h want 0003", data_out); end
        step();
        statusordata = 1'b0;
        step();
        for (int i = 1; i <= 4; i++) begin
            ack = 1'b1;
            #1;
            tests++; if (data_out !== 16'(i)) begin
                fails++; $display("FAIL ovf_pop%0d got %h want %h", i, data_out, 16'(i));
            end
            ack_hold();
        end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL ovf_empty got %b want 1", empty); end
    endtask

    task automatic test_simul_full();
        for (int i = 1; i <= 4; i++) push(4'(i));
        key_code = 4'h9; key_valid = 1'b1; ack = 1'b1;
        #1;
        tests++; if (data_out !== 16'h0001) begin fails++; $display("FAIL simul_head got %h want 0001", data_out); end
        step();
        key_valid = 1'b0; ack = 1'b0;
        step();
        tests++; if (count !== 3'd4) begin fails++; $display("FAIL simul_count got %0d want 4", count); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL simul_ovf got %b want 0", overflow); end
        for (int i = 0; i < 4; i++) begin
            logic [15:0] exp;
            exp = (i == 3) ? 16'h0009 : 16'(i + 2);
            ack = 1'b1;
            #1;
            tests++; if (data_out !== exp) begin
                fails++; $display("FAIL simul_pop%0d got %h want %h", i, data_out, exp);
            end
            ack_hold();
        end
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL simul_end got %0d want 0", count); end
    endtask

    task automatic test_empty_pop();
        for (int i = 0; i < 2; i++) begin
            ack = 1'b1;
            #1;
            tests++; if (data_out !== 16'h0000) begin fails++; $display("FAIL empty_data%0d got %h want 0000", i, data_out); end
            step();
            ack = 1'b0;
            step();
            tests++; if (count !== 3'd0) begin fails++; $display("FAIL empty_count%0d got %0d want 0", i, count); end
        end
        key_code = 4'h7; key_valid = 1'b1; ack = 1'b1;
        step();
        key_valid = 1'b0; ack = 1'b0;
        tests++; if (count !== 3'd1) begin fails++; $display("FAIL empty_pp_count got %0d want 1", count); end
        #1;
        tests++; if (data_out !== 16'h0007) begin fails++; $display("FAIL empty_pp_head got %h want 0007", data_out); end
        step();
        ack = 1'b1;
        ack_hold();
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL empty_pp_drain got %b want 1", empty); end
    endtask

    task automatic test_hold_and_reset();
        key_code = 4'h8; key_valid = 1'b1;
        repeat (10) step();
        key_valid = 1'b0;
        step();
        tests++; if (count !== 3'd1) begin fails++; $display("FAIL hold_count got %0d want 1", count); end
        key_code = 4'hB; rst = 1'b1; ack = 1'b1; key_valid = 1'b1;
        step();
        step();
        rst = 1'b0;
        repeat (3) step();
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL rst_held_count got %0d want 0", count); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL rst_held_empty got %b want 1", empty); end
        ack = 1'b0; key_valid = 1'b0;
        step();
        push(4'hC);
        tests++; if (count !== 3'd1) begin fails++; $display("FAIL rst_toggle_count got %0d want 1", count); end
        tests++; if (data_out !== 16'h000C) begin fails++; $display("FAIL rst_toggle_head got %h want 000c", data_out); end
        ack = 1'b1;
        ack_hold();
    endtask

    task automatic test_stat_drop();
        for (int i = 1; i <= 5; i++) push(4'(i));
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL sd_set got %b want 1", overflow); end
        statusordata = 1'b1; key_code = 4'h6; key_valid = 1'b1;
        #1;
        tests++; if (data_out !== 16'h0007) begin fails++; $display("FAIL sd_stat1 got %h want 0007", data_out); end
        step();
        statusordata = 1'b0; key_valid = 1'b0;
        step();
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL sd_keep got %b want 1", overflow); end
        statusordata = 1'b1;
        #1;
        tests++; if (data_out !== 16'h0007) begin fails++; $display("FAIL sd_stat2 got %h want 0007", data_out); end
        step();
        statusordata = 1'b0;
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL sd_clear got %b want 0", overflow); end
        step();
        statusordata = 1'b1;
        #1;
        tests++; if (data_out !== 16'h0003) begin fails++; $display("FAIL sd_stat3 got %h want 0003", data_out); end
        step();
        statusordata = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_simul_full();
        test_empty_pop();
        test_hold_and_reset();
        test_stat_drop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
